// File: rtl/frat_multiway.sv
// -----------------------------------------------------------------------------
// frat_multiway
// Front-end register alias table for the out-of-order MIPS core. It renames up
// to WAYS instructions per cycle. It bypasses tags produced inside the same
// group. It returns the previous rd mapping so that commit can free it. On a
// flush it reloads the map from the retirement RAT.
//
// Optional build macro: FRAT_CKPT_EN. It adds one branch checkpoint (a shadow
// table) with the ports ckpt_save, ckpt_slot and ckpt_restore.
//
// Ports
//   CLK, RESET_N        clock and asynchronous active-low reset
//   flush, rrat_backup  recovery request and committed map (entry i at i*PREG_W)
//   in_valid/in_ready   decode group handshake
//   way_valid, dst_we   per-slot presence and rd-write flags
//   rs/rt/rd_arch       architectural indices, packed per slot
//   fl_valid, fl_preg   free-list tags offered per slot
//   fl_pop              per-slot free-list consume (same cycle as accept)
//   out_valid/out_ready renamed group handshake (one-cycle latency)
//   out_way_valid, out_rs_p, out_rt_p, out_rd_p, out_old_rd_p  renamed group
// -----------------------------------------------------------------------------
module frat_multiway #(
    parameter int NUM_ARCH = 34,
    parameter int ARCH_W   = 6,
    parameter int PREG_W   = 6,
    parameter int WAYS     = 2
) (
    input  logic                       CLK,
    input  logic                       RESET_N,
    input  logic                       flush,
    input  logic [NUM_ARCH*PREG_W-1:0] rrat_backup,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WAYS-1:0]            way_valid,
    input  logic [WAYS-1:0]            dst_we,
    input  logic [WAYS*ARCH_W-1:0]     rs_arch,
    input  logic [WAYS*ARCH_W-1:0]     rt_arch,
    input  logic [WAYS*ARCH_W-1:0]     rd_arch,
    input  logic [WAYS-1:0]            fl_valid,
    input  logic [WAYS*PREG_W-1:0]     fl_preg,
    output logic [WAYS-1:0]            fl_pop,
`ifdef FRAT_CKPT_EN
    input  logic                       ckpt_save,
    input  logic [WAYS-1:0]            ckpt_slot,
    input  logic                       ckpt_restore,
`endif
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WAYS-1:0]            out_way_valid,
    output logic [WAYS*PREG_W-1:0]     out_rs_p,
    output logic [WAYS*PREG_W-1:0]     out_rt_p,
    output logic [WAYS*PREG_W-1:0]     out_rd_p,
    output logic [WAYS*PREG_W-1:0]     out_old_rd_p
);

    localparam logic [ARCH_W:0] ARCH_LIM = (ARCH_W+1)'(NUM_ARCH);

    logic [PREG_W-1:0] table_r     [NUM_ARCH];
    logic [PREG_W-1:0] table_nxt_s [NUM_ARCH];

    logic [ARCH_W-1:0] rs_a_s [WAYS];
    logic [ARCH_W-1:0] rt_a_s [WAYS];
    logic [ARCH_W-1:0] rd_a_s [WAYS];
    logic [PREG_W-1:0] fl_s   [WAYS];
    logic [PREG_W-1:0] rs_p_s [WAYS];
    logic [PREG_W-1:0] rt_p_s [WAYS];
    logic [PREG_W-1:0] old_s  [WAYS];
    logic [PREG_W-1:0] rd_p_s [WAYS];
    logic [WAYS-1:0]   need_s;
    logic              in_ready_s;
    logic              accept_s;

    logic                   out_valid_r;
    logic [WAYS-1:0]        out_way_valid_r;
    logic [WAYS*PREG_W-1:0] out_rs_p_r;
    logic [WAYS*PREG_W-1:0] out_rt_p_r;
    logic [WAYS*PREG_W-1:0] out_rd_p_r;
    logic [WAYS*PREG_W-1:0] out_old_rd_p_r;

`ifdef FRAT_CKPT_EN
    logic [PREG_W-1:0] shadow_r   [NUM_ARCH];
    logic [PREG_W-1:0] ckpt_tab_s [NUM_ARCH];
    logic [WAYS-1:0]   ckpt_upto_s;
`endif

    // Indices beyond the architectural range read as tag 0.
    function automatic logic in_range(input logic [ARCH_W-1:0] a);
        return ({1'b0, a} < ARCH_LIM);
    endfunction

    // Unpack the per-slot fields and work out which slots allocate a new tag.
    always_comb begin
        for (int j = 0; j < WAYS; j++) begin
            rs_a_s[j] = rs_arch[j*ARCH_W +: ARCH_W];
            rt_a_s[j] = rt_arch[j*ARCH_W +: ARCH_W];
            rd_a_s[j] = rd_arch[j*ARCH_W +: ARCH_W];
            fl_s[j]   = fl_preg[j*PREG_W +: PREG_W];
            need_s[j] = way_valid[j] && dst_we[j] && (rd_a_s[j] != {ARCH_W{1'b0}});
        end
    end

    // Source and old-rd lookup. Scanning older slots upward lets the youngest
    // earlier writer win the bypass.
    always_comb begin
        for (int j = 0; j < WAYS; j++) begin
            rs_p_s[j] = in_range(rs_a_s[j]) ? table_r[rs_a_s[j]] : {PREG_W{1'b0}};
            rt_p_s[j] = in_range(rt_a_s[j]) ? table_r[rt_a_s[j]] : {PREG_W{1'b0}};
            old_s[j]  = in_range(rd_a_s[j]) ? table_r[rd_a_s[j]] : {PREG_W{1'b0}};
            for (int k = 0; k < j; k++) begin
                rs_p_s[j] = (need_s[k] && rd_a_s[k] == rs_a_s[j]) ? fl_s[k] : rs_p_s[j];
                rt_p_s[j] = (need_s[k] && rd_a_s[k] == rt_a_s[j]) ? fl_s[k] : rt_p_s[j];
                old_s[j]  = (need_s[k] && rd_a_s[k] == rd_a_s[j]) ? fl_s[k] : old_s[j];
            end
            rd_p_s[j] = need_s[j] ? fl_s[j] : old_s[j];
        end
    end

    // Next table contents after the group. The last matching slot wins per register.
    always_comb begin
        for (int r = 0; r < NUM_ARCH; r++) begin
            table_nxt_s[r] = table_r[r];
            for (int j = 0; j < WAYS; j++) begin
                table_nxt_s[r] = (need_s[j] && rd_a_s[j] == ARCH_W'(r)) ? fl_s[j]
                                                                         : table_nxt_s[r];
            end
        end
    end

`ifdef FRAT_CKPT_EN
    // Checkpoint image: apply only the slots at or before the marked branch slot.
    always_comb begin
        for (int j = 0; j < WAYS; j++) begin
            ckpt_upto_s[j] = |(ckpt_slot >> j);
        end
        for (int r = 0; r < NUM_ARCH; r++) begin
            ckpt_tab_s[r] = table_r[r];
            for (int j = 0; j < WAYS; j++) begin
                ckpt_tab_s[r] = (ckpt_upto_s[j] && need_s[j] && rd_a_s[j] == ARCH_W'(r))
                                ? fl_s[j] : ckpt_tab_s[r];
            end
        end
    end
`endif

    // Accept only when every allocating slot has a free tag and the output
    // stage is free or draining. Recovery cycles accept nothing.
    always_comb begin
        in_ready_s = RESET_N && !flush && (!out_valid_r || out_ready)
                     && (&(~need_s | fl_valid));
`ifdef FRAT_CKPT_EN
        in_ready_s = in_ready_s && !ckpt_restore;
`endif
        accept_s = in_valid && in_ready_s;
    end

    assign in_ready = in_ready_s;
    assign fl_pop   = {WAYS{accept_s}} & need_s;

    // Map table and output stage. Flush has top priority, then checkpoint
    // restore, then accept.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < NUM_ARCH; i++) begin
                table_r[i] <= PREG_W'(i);
            end
            out_valid_r     <= 1'b0;
            out_way_valid_r <= {WAYS{1'b0}};
            out_rs_p_r      <= {(WAYS*PREG_W){1'b0}};
            out_rt_p_r      <= {(WAYS*PREG_W){1'b0}};
            out_rd_p_r      <= {(WAYS*PREG_W){1'b0}};
            out_old_rd_p_r  <= {(WAYS*PREG_W){1'b0}};
        end else if (flush) begin
            for (int i = 0; i < NUM_ARCH; i++) begin
                table_r[i] <= rrat_backup[i*PREG_W +: PREG_W];
            end
            out_valid_r <= 1'b0;
`ifdef FRAT_CKPT_EN
        end else if (ckpt_restore) begin
            table_r     <= shadow_r;
            out_valid_r <= 1'b0;
`endif
        end else if (accept_s) begin
            table_r         <= table_nxt_s;
            out_valid_r     <= 1'b1;
            out_way_valid_r <= way_valid;
            for (int j = 0; j < WAYS; j++) begin
                out_rs_p_r[j*PREG_W +: PREG_W]     <= rs_p_s[j];
                out_rt_p_r[j*PREG_W +: PREG_W]     <= rt_p_s[j];
                out_rd_p_r[j*PREG_W +: PREG_W]     <= rd_p_s[j];
                out_old_rd_p_r[j*PREG_W +: PREG_W] <= old_s[j];
            end
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

`ifdef FRAT_CKPT_EN
    // Shadow table capture for branch recovery.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < NUM_ARCH; i++) begin
                shadow_r[i] <= PREG_W'(i);
            end
        end else if (accept_s && ckpt_save) begin
            shadow_r <= ckpt_tab_s;
        end else begin
            shadow_r <= shadow_r;
        end
    end
`endif

    assign out_valid     = out_valid_r;
    assign out_way_valid = out_way_valid_r;
    assign out_rs_p      = out_rs_p_r;
    assign out_rt_p      = out_rt_p_r;
    assign out_rd_p      = out_rd_p_r;
    assign out_old_rd_p  = out_old_rd_p_r;

endmodule

// File: tb/tb_frat_multiway.sv
// -----------------------------------------------------------------------------
// tb_frat_multiway
// Directed scoreboard bench for frat_multiway with the default parameters
// (WAYS=2, PREG_W=6). The driver pushes the hand-computed renamed group of
// each accepted group. The monitor pops and compares on every output handshake.
// -----------------------------------------------------------------------------
module tb_frat_multiway;

    localparam int NA = 34;
    localparam int AW = 6;
    localparam int PW = 6;
    localparam int W  = 2;

    logic              CLK;
    logic              RESET_N;
    logic              flush;
    logic [NA*PW-1:0]  rrat_backup;
    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      way_valid;
    logic [W-1:0]      dst_we;
    logic [W*AW-1:0]   rs_arch;
    logic [W*AW-1:0]   rt_arch;
    logic [W*AW-1:0]   rd_arch;
    logic [W-1:0]      fl_valid;
    logic [W*PW-1:0]   fl_preg;
    logic [W-1:0]      fl_pop;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      out_way_valid;
    logic [W*PW-1:0]   out_rs_p;
    logic [W*PW-1:0]   out_rt_p;
    logic [W*PW-1:0]   out_rd_p;
    logic [W*PW-1:0]   out_old_rd_p;
`ifdef FRAT_CKPT_EN
    logic              ckpt_save;
    logic [W-1:0]      ckpt_slot;
    logic              ckpt_restore;
`endif

    typedef struct packed {
        logic [7:0]      id;
        logic [W-1:0]    wv;
        logic [W*PW-1:0] rs;
        logic [W*PW-1:0] rt;
        logic [W*PW-1:0] rd;
        logic [W*PW-1:0] old;
    } grp_t;

    grp_t q[$];
    int   checks;
    int   failures;

    frat_multiway #(.NUM_ARCH(NA), .ARCH_W(AW), .PREG_W(PW), .WAYS(W)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .flush(flush), .rrat_backup(rrat_backup),
        .in_valid(in_valid), .in_ready(in_ready), .way_valid(way_valid),
        .dst_we(dst_we), .rs_arch(rs_arch), .rt_arch(rt_arch), .rd_arch(rd_arch),
        .fl_valid(fl_valid), .fl_preg(fl_preg), .fl_pop(fl_pop),
`ifdef FRAT_CKPT_EN
        .ckpt_save(ckpt_save), .ckpt_slot(ckpt_slot), .ckpt_restore(ckpt_restore),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_way_valid(out_way_valid),
        .out_rs_p(out_rs_p), .out_rt_p(out_rt_p), .out_rd_p(out_rd_p),
        .out_old_rd_p(out_old_rd_p)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [W*PW-1:0] pk(input int s1, input int s0);
        logic [PW-1:0] a1;
        logic [PW-1:0] a0;
        a1 = PW'(s1);
        a0 = PW'(s0);
        return {a1, a0};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic set_grp(input logic [1:0] wv, input logic [1:0] we,
                           input int rs1, input int rs0, input int rt1, input int rt0,
                           input int rd1, input int rd0, input logic [1:0] flv,
                           input int fl1, input int fl0);
        in_valid  = 1'b1;
        way_valid = wv;
        dst_we    = we;
        rs_arch   = pk(rs1, rs0);
        rt_arch   = pk(rt1, rt0);
        rd_arch   = pk(rd1, rd0);
        fl_valid  = flv;
        fl_preg   = pk(fl1, fl0);
    endtask

    // One cycle: check the handshake at the falling edge and queue the expected
    // group if it should be accepted. The task returns 1 ns after the rising edge.
    task automatic step(input int id, input logic exp_rdy, input logic [1:0] exp_pop,
                        input logic [W*PW-1:0] ers, input logic [W*PW-1:0] ert,
                        input logic [W*PW-1:0] erd, input logic [W*PW-1:0] eold);
        grp_t g;
        @(negedge CLK);
        chk($sformatf("g%0d_in_ready", id), 32'(in_ready), 32'(exp_rdy));
        chk($sformatf("g%0d_fl_pop", id), 32'(fl_pop), 32'(exp_pop));
        if (exp_rdy) begin
            g.id  = 8'(id);
            g.wv  = way_valid;
            g.rs  = ers;
            g.rt  = ert;
            g.rd  = erd;
            g.old = eold;
            q.push_back(g);
        end
        @(posedge CLK);
        #1;
    endtask

    // Monitor: compare each group the consumer takes against the queue head.
    always @(negedge CLK) begin
        if (RESET_N && out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_group got rs_p=%h want none", out_rs_p);
            end else begin
                grp_t e;
                e = q.pop_front();
                chk($sformatf("g%0d_way_valid", e.id), 32'(out_way_valid), 32'(e.wv));
                chk($sformatf("g%0d_rs_p", e.id), 32'(out_rs_p), 32'(e.rs));
                chk($sformatf("g%0d_rt_p", e.id), 32'(out_rt_p), 32'(e.rt));
                chk($sformatf("g%0d_rd_p", e.id), 32'(out_rd_p), 32'(e.rd));
                chk($sformatf("g%0d_old_rd_p", e.id), 32'(out_old_rd_p), 32'(e.old));
            end
        end
    end

    initial begin
        checks    = 0;
        failures  = 0;
        RESET_N   = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
`ifdef FRAT_CKPT_EN
        ckpt_save    = 1'b0;
        ckpt_slot    = 2'b00;
        ckpt_restore = 1'b0;
`endif
        for (int i = 0; i < NA; i++) begin
            rrat_backup[i*PW +: PW] = (i == 7) ? PW'(20) : PW'(i);
        end
        // A group is offered during reset, so that in_ready and fl_pop must be suppressed.
        set_grp(2'b11, 2'b11, 0, 5, 0, 6, 2, 3, 2'b11, 11, 10);

        @(negedge CLK);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_fl_pop", 32'(fl_pop), 32'd0);
        chk("rst_out_rs_p", 32'(out_rs_p), 32'd0);
        chk("rst_out_way_valid", 32'(out_way_valid), 32'd0);
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;

        // G1: identity lookups, no writers.
        set_grp(2'b11, 2'b00, 0, 5, 1, 6, 4, 2, 2'b00, 0, 0);
        step(1, 1'b1, 2'b00, pk(0, 5), pk(1, 6), pk(4, 2), pk(4, 2));

        // G2: the same-group rd=3 bypass, and the old rd from the older slot.
        set_grp(2'b11, 2'b11, 3, 1, 4, 2, 3, 3, 2'b11, 41, 40);
        step(2, 1'b1, 2'b11, pk(40, 1), pk(4, 2), pk(41, 40), pk(40, 3));

        // G3: rd=0 with dst_we is not renamed. rs=3 now maps to 41.
        set_grp(2'b11, 2'b11, 0, 3, 0, 0, 0, 0, 2'b11, 51, 50);
        step(3, 1'b1, 2'b00, pk(0, 41), pk(0, 0), pk(0, 0), pk(0, 0));

        // Stall: out_ready is low for 3 cycles. G3 is held and G4 is refused.
        out_ready = 1'b0;
        set_grp(2'b11, 2'b01, 8, 3, 9, 7, 10, 8, 2'b01, 0, 42);
        for (int c = 0; c < 3; c++) begin
            step(4, 1'b0, 2'b00, '0, '0, '0, '0);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_hold_rs_p", 32'(out_rs_p), 32'(pk(0, 41)));
        end
        out_ready = 1'b1;
        step(4, 1'b1, 2'b01, pk(42, 41), pk(9, 7), pk(10, 42), pk(10, 8));

        // G5: the slot1 free tag is missing, so the group waits until it appears.
        set_grp(2'b11, 2'b10, 9, 8, 8, 3, 9, 1, 2'b01, 43, 0);
        step(5, 1'b0, 2'b00, '0, '0, '0, '0);
        step(5, 1'b0, 2'b00, '0, '0, '0, '0);
        fl_valid = 2'b11;
        step(5, 1'b1, 2'b10, pk(9, 42), pk(42, 41), pk(43, 1), pk(9, 1));

        // Flush while G5 is pending. The group is discarded and the table takes the RRAT values.
        out_ready = 1'b0;
        flush     = 1'b1;
        set_grp(2'b11, 2'b11, 7, 7, 7, 7, 7, 7, 2'b11, 60, 61);
        step(90, 1'b0, 2'b00, '0, '0, '0, '0);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        q.delete();
        @(negedge CLK);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        @(posedge CLK);
        #1;

        // G6: lookups after the flush. Arch 7 maps to 20 and the rest are identity.
        set_grp(2'b11, 2'b00, 9, 7, 8, 3, 7, 9, 2'b00, 0, 0);
        step(6, 1'b1, 2'b00, pk(9, 20), pk(8, 3), pk(20, 9), pk(20, 9));

        // G7: out-of-range indices read as 0, and the allocating slot still pops.
        set_grp(2'b11, 2'b01, 40, 40, 2, 33, 2, 50, 2'b01, 0, 44);
        step(7, 1'b1, 2'b01, pk(0, 0), pk(2, 33), pk(2, 44), pk(2, 0));

        // Drain with a bounded wait, then require an empty scoreboard.
        in_valid = 1'b0;
        for (int c = 0; c < 10 && q.size() != 0; c++) begin
            @(posedge CLK);
            #1;
        end
        @(negedge CLK);
        chk("drain_queue_empty", 32'(q.size()), 32'd0);
        chk("drain_out_valid", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
